// File: rtl/pipe_seq_if.sv
// Program-load / run-control bus between a host and pipe_sequencer.
// start and prog_we are single-cycle strobes accepted only while the sequencer is IDLE; there is no back-pressure.
interface pipe_seq_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic [7:0]    inst;
  logic          busy;
  logic          done;
  logic [7:0]    stall_cnt;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start,
    input  inst, busy, done, stall_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start,
    output inst, busy, done, stall_cnt
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Issues a stored program of one-hot instruction words to the MAC pipeline,
// inserting NOP bubbles so loads, MACs and writes keep their minimum spacing.
module pipe_sequencer #(
  parameter int DEPTH    = 16,
  parameter int LOAD_LAT = 2,
  parameter int MAC_LAT  = 3,
  parameter int DRAIN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  pipe_seq_if.slave  bus,
  output logic [1:0] fsm_state
);
  localparam int AW = $clog2(DEPTH);

  // One-hot instruction bit positions used by the pipeline.
  localparam int NOP      = 0;
  localparam int LD_DATA  = 1;
  localparam int LD_COEFF = 2;
  localparam int ADD      = 3;
  localparam int MULT     = 4;
  localparam int WRITE    = 5;

  localparam logic [7:0] NOP_W      = 8'(1 << NOP);
  localparam logic [7:0] LOAD_LAT_W = 8'(LOAD_LAT);
  localparam logic [7:0] MAC_LAT_W  = 8'(MAC_LAT);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] pc, pc_nxt;
  logic [AW:0]   len_q, len_nxt;
  logic [AW:0]   pc_inc;
  logic [7:0]    stall_q, stall_nxt;
  logic [7:0]    drain_cnt, drain_nxt;
  logic [7:0]    since_ld, since_mac;
  logic [7:0]    inst_q, inst_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic [7:0]    w, w_eff;
  logic          has_ld, has_mac, has_wr, hazard;
  logic          issue_ld, issue_mac;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Program memory has no reset: it survives a mid-run abort.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    w       = mem[pc];
    w_eff   = (w == 8'd0) ? NOP_W : w;
    has_ld  = w[LD_DATA] | w[LD_COEFF];
    has_mac = w[ADD] | w[MULT];
    has_wr  = w[WRITE];
    hazard  = (has_mac && (since_ld < LOAD_LAT_W)) ||
              (has_wr && (since_mac < MAC_LAT_W));
    pc_inc  = {1'b0, pc} + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    len_nxt   = len_q;
    stall_nxt = stall_q;
    drain_nxt = drain_cnt;
    inst_nxt  = NOP_W;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    issue_ld  = 1'b0;
    issue_mac = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          len_nxt   = bus.prog_len;
          stall_nxt = 8'd0;
          pc_nxt    = '0;
          drain_nxt = 8'd0;
          state_nxt = (bus.prog_len == '0) ? S_DRAIN : S_RUN;
        end
      end

      S_RUN: begin
        busy_nxt = 1'b1;
        if (hazard) begin
          stall_nxt = sat_inc(stall_q);
        end else begin
          inst_nxt  = w_eff;
          issue_ld  = has_ld;
          issue_mac = has_mac;
          pc_nxt    = pc_inc[AW-1:0];
          if (pc_inc == len_q) begin
            state_nxt = S_DRAIN;
            drain_nxt = 8'd0;
          end
        end
      end

      S_DRAIN: begin
        busy_nxt = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          drain_nxt = drain_cnt + 8'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      len_q     <= '0;
      stall_q   <= 8'd0;
      drain_cnt <= 8'd0;
      inst_q    <= NOP_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      since_ld  <= 8'hFF;
      since_mac <= 8'hFF;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      len_q     <= len_nxt;
      stall_q   <= stall_nxt;
      drain_cnt <= drain_nxt;
      inst_q    <= inst_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      // Counters always age; a word holding both a load and a MAC restarts both.
      since_ld  <= issue_ld  ? 8'd1 : sat_inc(since_ld);
      since_mac <= issue_mac ? 8'd1 : sat_inc(since_mac);
    end
  end

  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall_cnt = stall_q;
  assign fsm_state     = state;
endmodule
